// File: rtl/static_hazard_monitor.sv
// Observes a 3-input hazard-free logic block and classifies output activity after each input change.
// Inputs are double-flop synchronised; classification closes SETTLE_CYCLES after the last input change.
module static_hazard_monitor #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             out_obs,
    output logic             hazard_flag,
    output logic             mismatch_flag,
    output logic [CNT_W-1:0] static0_cnt,
    output logic [CNT_W-1:0] static1_cnt,
    output logic [CNT_W-1:0] dyn_cnt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             busy
);

    localparam logic [7:0] WIN_INIT = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STABLE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Golden function with v = {a,b,c}.
    function automatic logic golden(input logic [2:0] v);
        golden = (~v[0] & ~v[2]) | (v[1] & v[0]) | (v[2] & ~v[1]);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        sat_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    endfunction

    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [2:0] vec;
    logic       o;
    logic [2:0] vec_prev;
    logic       o_prev;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] win_cnt;
    logic [7:0] win_nxt;
    logic [1:0] tog_cnt;
    logic [1:0] tog_nxt;
    logic [1:0] tog_sum;
    logic       exp_old;
    logic       exp_old_nxt;
    logic       exp_new;
    logic       exp_new_nxt;
    logic       mis_prev;

    logic       vec_chg;
    logic       tog_now;
    logic       f_vec;
    logic       mis_now;

    logic       static0_ev;
    logic       static1_ev;
    logic       dyn_ev;
    logic       mis_ev;

    assign vec     = sync2[3:1];
    assign o       = sync2[0];
    assign vec_chg = (vec != vec_prev);
    assign tog_now = (o != o_prev);
    assign f_vec   = golden(vec);
    assign mis_now = (o != f_vec);
    assign tog_sum = (tog_now && (tog_cnt != 2'd3)) ? tog_cnt + 2'd1 : tog_cnt;
    assign busy    = (state == SETTLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1    <= '0;
            sync2    <= '0;
            vec_prev <= '0;
            o_prev   <= 1'b0;
        end else begin
            sync1    <= {a, b, c, out_obs};
            sync2    <= sync1;
            vec_prev <= vec;
            o_prev   <= o;
        end
    end

    always_comb begin
        state_nxt   = state;
        win_nxt     = win_cnt;
        tog_nxt     = tog_cnt;
        exp_old_nxt = exp_old;
        exp_new_nxt = exp_new;
        static0_ev  = 1'b0;
        static1_ev  = 1'b0;
        dyn_ev      = 1'b0;
        mis_ev      = 1'b0;

        case (state)
            IDLE: begin
                if (en) state_nxt = STABLE;
            end
            STABLE: begin
                if (vec_chg) begin
                    exp_old_nxt = golden(vec_prev);
                    exp_new_nxt = f_vec;
                    win_nxt     = WIN_INIT;
                    tog_nxt     = 2'd0;
                    state_nxt   = SETTLE;
                end else if (mis_now && !mis_prev) begin
                    mis_ev = 1'b1;
                end
            end
            SETTLE: begin
                tog_nxt = tog_sum;
                // A further input change extends the same transition rather than closing it.
                if (vec_chg) begin
                    win_nxt     = WIN_INIT;
                    exp_new_nxt = f_vec;
                end else if (win_cnt <= 8'd1) begin
                    win_nxt   = 8'd0;
                    state_nxt = STABLE;
                    if ((exp_old == exp_new) && (tog_sum != 2'd0)) begin
                        static1_ev = exp_new;
                        static0_ev = ~exp_new;
                    end
                    if ((exp_old != exp_new) && (tog_sum >= 2'd2)) begin
                        dyn_ev = 1'b1;
                    end
                    if (o != exp_new) begin
                        mis_ev = 1'b1;
                    end
                end else begin
                    win_nxt = win_cnt - 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (!en) begin
            state_nxt  = IDLE;
            static0_ev = 1'b0;
            static1_ev = 1'b0;
            dyn_ev     = 1'b0;
            mis_ev     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            win_cnt       <= '0;
            tog_cnt       <= '0;
            exp_old       <= 1'b0;
            exp_new       <= 1'b0;
            mis_prev      <= 1'b0;
            hazard_flag   <= 1'b0;
            mismatch_flag <= 1'b0;
            static0_cnt   <= '0;
            static1_cnt   <= '0;
            dyn_cnt       <= '0;
            mismatch_cnt  <= '0;
        end else begin
            state         <= state_nxt;
            win_cnt       <= win_nxt;
            tog_cnt       <= tog_nxt;
            exp_old       <= exp_old_nxt;
            exp_new       <= exp_new_nxt;
            // Clearing in IDLE lets a mismatch already present at enable be reported once.
            mis_prev      <= en && (state != IDLE) && mis_now;
            hazard_flag   <= static0_ev | static1_ev | dyn_ev;
            mismatch_flag <= mis_ev;
            if (static0_ev) static0_cnt  <= sat_inc(static0_cnt);
            if (static1_ev) static1_cnt  <= sat_inc(static1_cnt);
            if (dyn_ev)     dyn_cnt      <= sat_inc(dyn_cnt);
            if (mis_ev)     mismatch_cnt <= sat_inc(mismatch_cnt);
        end
    end

endmodule

// File: tb/tb_static_hazard_monitor.sv
// Scenario bench for static_hazard_monitor: a default instance and a CNT_W=2 instance share stimulus.
module tb_static_hazard_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       a;
    logic       b;
    logic       c;
    logic       out_obs;

    logic       hazard_flag;
    logic       mismatch_flag;
    logic [7:0] static0_cnt;
    logic [7:0] static1_cnt;
    logic [7:0] dyn_cnt;
    logic [7:0] mismatch_cnt;
    logic       busy;

    logic       s_hazard_flag;
    logic       s_mismatch_flag;
    logic [1:0] s_static0_cnt;
    logic [1:0] s_static1_cnt;
    logic [1:0] s_dyn_cnt;
    logic [1:0] s_mismatch_cnt;
    logic       s_busy;

    static_hazard_monitor #(.SETTLE_CYCLES(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .out_obs(out_obs),
        .hazard_flag(hazard_flag), .mismatch_flag(mismatch_flag),
        .static0_cnt(static0_cnt), .static1_cnt(static1_cnt),
        .dyn_cnt(dyn_cnt), .mismatch_cnt(mismatch_cnt), .busy(busy)
    );

    static_hazard_monitor #(.SETTLE_CYCLES(4), .CNT_W(2)) dut_small (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .c(c), .out_obs(out_obs),
        .hazard_flag(s_hazard_flag), .mismatch_flag(s_mismatch_flag),
        .static0_cnt(s_static0_cnt), .static1_cnt(s_static1_cnt),
        .dyn_cnt(s_dyn_cnt), .mismatch_cnt(s_mismatch_cnt), .busy(s_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int hz_tot   = 0;
    int mm_tot   = 0;
    int busy_tot = 0;
    int s_hz_tot = 0;
    int s_mm_tot = 0;

    always @(negedge clk) begin
        if (hazard_flag)     hz_tot++;
        if (mismatch_flag)   mm_tot++;
        if (busy)            busy_tot++;
        if (s_hazard_flag)   s_hz_tot++;
        if (s_mismatch_flag) s_mm_tot++;
    end

    typedef struct {
        int s0;
        int s1;
        int dyn;
        int mis;
        int hz;
        int mm;
        int bsy;
    } exp_t;

    exp_t exp_q[$];

    int e_s0  = 0;
    int e_s1  = 0;
    int e_dyn = 0;
    int e_mis = 0;
    int hz0, mm0, busy0, shz0, smm0;

    task automatic check_val(input string tag, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic int sat3(input int x);
        return (x > 3) ? 3 : x;
    endfunction

    task automatic drive(input logic [2:0] v, input logic o);
        {a, b, c} = v;
        out_obs   = o;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_scn(input int hz, input int mm, input int bsy);
        exp_t e;
        hz0   = hz_tot;
        mm0   = mm_tot;
        busy0 = busy_tot;
        shz0  = s_hz_tot;
        smm0  = s_mm_tot;
        e.s0  = e_s0;
        e.s1  = e_s1;
        e.dyn = e_dyn;
        e.mis = e_mis;
        e.hz  = hz;
        e.mm  = mm;
        e.bsy = bsy;
        exp_q.push_back(e);
    endtask

    task automatic end_scn(input string tag);
        exp_t e;
        e = exp_q.pop_front();
        check_val({tag, ".static0"},  int'(static0_cnt),  e.s0);
        check_val({tag, ".static1"},  int'(static1_cnt),  e.s1);
        check_val({tag, ".dyn"},      int'(dyn_cnt),      e.dyn);
        check_val({tag, ".mismatch"}, int'(mismatch_cnt), e.mis);
        check_val({tag, ".hz_pulses"}, hz_tot - hz0,      e.hz);
        check_val({tag, ".mm_pulses"}, mm_tot - mm0,      e.mm);
        check_val({tag, ".busy_cyc"},  busy_tot - busy0, e.bsy);
        check_val({tag, ".w2_static0"},  int'(s_static0_cnt),  sat3(e.s0));
        check_val({tag, ".w2_static1"},  int'(s_static1_cnt),  sat3(e.s1));
        check_val({tag, ".w2_dyn"},      int'(s_dyn_cnt),      sat3(e.dyn));
        check_val({tag, ".w2_mismatch"}, int'(s_mismatch_cnt), sat3(e.mis));
        check_val({tag, ".w2_hz_pulses"}, s_hz_tot - shz0,    e.hz);
        check_val({tag, ".w2_mm_pulses"}, s_mm_tot - smm0,    e.mm);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, ".hazard_flag"},   int'(hazard_flag),   0);
        check_val({tag, ".mismatch_flag"}, int'(mismatch_flag), 0);
        check_val({tag, ".static0"},       int'(static0_cnt),   0);
        check_val({tag, ".static1"},       int'(static1_cnt),   0);
        check_val({tag, ".dyn"},           int'(dyn_cnt),       0);
        check_val({tag, ".mismatch"},      int'(mismatch_cnt),  0);
        check_val({tag, ".busy"},          int'(busy),          0);
        check_val({tag, ".w2_static1"},    int'(s_static1_cnt), 0);
        check_val({tag, ".w2_busy"},       int'(s_busy),        0);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        drive(3'b000, 1'b0);
        step(3);
        check_all_zero("reset");

        rst_n = 1'b1;
        drive(3'b011, 1'b1);
        step(5);
        en = 1'b1;
        step(6);

        // Static-1 glitch: 011 -> 010, output 1 -> 0 -> 1.
        e_s1++;
        begin_scn(1, 0, 4);
        drive(3'b010, 1'b1);
        step(1);
        out_obs = 1'b0;
        step(1);
        out_obs = 1'b1;
        step(12);
        end_scn("static1_glitch");

        // Clean single output transition on a 1 -> 0 input change.
        drive(3'b000, 1'b1);
        step(12);
        begin_scn(0, 0, 4);
        drive(3'b001, 1'b1);
        step(1);
        out_obs = 1'b0;
        step(12);
        end_scn("clean_fall");

        // Dynamic hazard: output 1 -> 0 -> 1 -> 0.
        drive(3'b000, 1'b1);
        step(12);
        e_dyn++;
        begin_scn(1, 0, 4);
        drive(3'b001, 1'b1);
        step(1);
        out_obs = 1'b0;
        step(1);
        out_obs = 1'b1;
        step(1);
        out_obs = 1'b0;
        step(12);
        end_scn("dynamic");

        // Held steady-state mismatch counts once per episode.
        e_mis++;
        begin_scn(0, 1, 4);
        drive(3'b110, 1'b1);
        step(20);
        end_scn("mismatch_hold");
        e_mis++;
        begin_scn(0, 1, 0);
        out_obs = 1'b0;
        step(5);
        out_obs = 1'b1;
        step(10);
        end_scn("mismatch_again");
        out_obs = 1'b0;
        step(5);

        // Reset mid-window discards the open window.
        drive(3'b000, 1'b1);
        step(12);
        e_s0 = 0; e_s1 = 0; e_dyn = 0; e_mis = 0;
        begin_scn(0, 0, 2);
        drive(3'b010, 1'b1);
        step(1);
        out_obs = 1'b0;
        step(3);
        check_val("pre_reset.busy", int'(busy), 1);
        rst_n   = 1'b0;
        out_obs = 1'b1;
        step(1);
        check_all_zero("mid_reset");
        rst_n = 1'b1;
        en    = 1'b0;
        step(5);
        en = 1'b1;
        step(6);
        end_scn("after_reset");

        // Multi-step change 001 -> 011 -> 010 forms one window.
        drive(3'b001, 1'b0);
        step(12);
        begin_scn(0, 0, 5);
        drive(3'b011, 1'b0);
        step(1);
        drive(3'b010, 1'b0);
        step(1);
        out_obs = 1'b1;
        step(12);
        end_scn("multi_step");

        // Five static-1 glitches; the 2-bit instance saturates at 3.
        e_s1 += 5;
        begin_scn(5, 0, 20);
        for (int i = 0; i < 5; i++) begin
            drive((i % 2 == 0) ? 3'b011 : 3'b010, 1'b1);
            step(1);
            out_obs = 1'b0;
            step(1);
            out_obs = 1'b1;
            step(12);
        end
        end_scn("saturate");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/static_hazard_monitor.md
Name: static_hazard_monitor

Overview:
Clocked checker on the observing side of the team's hazard-free combinational logic. It samples the three logic inputs and the observed output, and computes the golden function out = (~c & ~a) | (b & c) | (a & ~b). After every input change it opens a settle window and classifies output activity in that window as clean, static-0 hazard, static-1 hazard, dynamic hazard, or steady-state mismatch. It sits beside the logic under test in simulation and FPGA bring-up, and its clock is fast relative to the gate delays.

Parameters:
SETTLE_CYCLES, 4, clk cycles after the last input change during which output toggles are counted (legal range 1..255).
CNT_W, 8, width of each event counter.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  synchronous active-low reset.
en  input  1  monitor enable; low forces IDLE, counters hold.
a  input  1  logic input a (asynchronous to clk).
b  input  1  logic input b (asynchronous to clk).
c  input  1  logic input c (asynchronous to clk).
out_obs  input  1  observed output of the logic under test (asynchronous to clk).
hazard_flag  output  1  one-cycle pulse when any hazard is classified.
mismatch_flag  output  1  one-cycle pulse on a settled-value mismatch.
static0_cnt  output  CNT_W  count of static-0 hazards.
static1_cnt  output  CNT_W  count of static-1 hazards.
dyn_cnt  output  CNT_W  count of dynamic hazards.
mismatch_cnt  output  CNT_W  count of mismatch episodes.
busy  output  1  high while in SETTLE.

Behaviour:
- Reset: clock edge with rst_n=0 clears all state. Every output is 0; FSM goes to IDLE; synchronisers and previous-sample registers are cleared. Reset overrides en and aborts any open window without counting it.
- Input capture: a, b, c and out_obs each pass through a 2-flop synchroniser. All logic below uses the synchronised values (vec = {a,b,c}, o). vec_prev and o_prev are the same values delayed one more cycle. Added latency is 2 cycles.
- Golden table (abc -> f): 000->1, 001->0, 010->1, 011->1, 100->1, 101->1, 110->0, 111->1.
- FSM states are IDLE, STABLE and SETTLE.
- IDLE:
  - When en=1, go to STABLE next cycle.
  - vec_prev and o_prev are loaded in IDLE, so no event fires on entry.
- STABLE:
  - If vec != vec_prev: latch exp_old = f(vec_prev) and exp_new = f(vec), load win_cnt = SETTLE_CYCLES, clear tog_cnt, go to SETTLE.
  - Otherwise, if o != f(vec) and the previous cycle was not mismatching: pulse mismatch_flag and increment mismatch_cnt. This counts once per episode, not once per cycle.
- SETTLE:
  - Each cycle with o != o_prev increments tog_cnt (2-bit, saturating at 3).
  - If vec changes again: reload win_cnt, set exp_new = f(vec), keep exp_old and tog_cnt. A multi-step input change is one transition.
  - Otherwise win_cnt decrements. When win_cnt reaches 0, classify in that cycle:
    - exp_old == exp_new and tog_cnt >= 1: static hazard. Increment static1_cnt if exp_new=1, else static0_cnt.
    - exp_old != exp_new and tog_cnt >= 2: dynamic hazard. Increment dyn_cnt.
    - Any hazard also pulses hazard_flag in the next cycle (registered).
    - Independently, if o != exp_new at close: pulse mismatch_flag and increment mismatch_cnt.
    - Then go to STABLE.
- busy = 1 exactly while the state is SETTLE.
- Counters saturate at all-ones and never wrap.
- en=0 in any state: go to IDLE next cycle. An open window is discarded; flags go 0; counters hold.
- Simultaneous close and vec change in the same cycle: the change wins, the window is reloaded and no classification occurs.

Test Plan:
- Reset then en=1, vec 011->010 with out_obs 1->0->1 within 2 cycles -> static1_cnt=1, hazard_flag one pulse, all other counters 0.
- vec 000->001, out_obs single 1->0 -> all counters 0, no flags, busy high for exactly 4 cycles.
- vec 000->001, out_obs 1->0->1->0 inside window -> dyn_cnt=1, hazard_flag pulses once.
- Hold vec=110 with out_obs=1 for 20 cycles -> mismatch_cnt=1, mismatch_flag single pulse; drop out_obs to 0, raise to 1 again -> mismatch_cnt=2.
- rst_n=0 for one cycle mid-SETTLE after a glitch -> all outputs 0 next cycle, no count recorded; vec changing 001->011->010 back-to-back -> one window, exp_old=0, exp_new=1, one toggle -> no hazard.
- CNT_W=2, repeat static-1 glitch 5 times -> static1_cnt saturates at 3, hazard_flag still pulses 5 times.
